// File: rtl/nn_argmax_head.sv
// nn_argmax_head: streaming argmax over one frame of NUM_CLASSES signed scores.
// The result (class index, max score, frame-length error) sits in a single-entry
// valid/ready register. Optional margin output (best - second best) is enabled
// with the NN_ARGMAX_MARGIN_EN macro.
module nn_argmax_head #(
  parameter int INWIDTH     = 16,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 din_valid,
  input  logic [INWIDTH-1:0]   din_data,
  output logic                 din_ready,
  input  logic                 din_last,
  output logic                 dout_valid,
  output logic [IDX_WIDTH-1:0] dout_class,
  output logic [INWIDTH-1:0]   dout_score,
  output logic                 dout_err,
  input  logic                 dout_ready
`ifdef NN_ARGMAX_MARGIN_EN
  ,output logic [INWIDTH-1:0]  dout_margin
`endif
);

  typedef enum logic {ACC, HOLD} state_t;

  typedef struct packed {
    logic [IDX_WIDTH-1:0] cls;
    logic [INWIDTH-1:0]   score;
    logic                 err;
  } res_t;

  localparam logic [INWIDTH-1:0]   MOST_NEG = {1'b1, {(INWIDTH-1){1'b0}}};
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

  state_t               state_q, state_d;
  logic [IDX_WIDTH-1:0] count_q, count_d;
  logic [INWIDTH-1:0]   best_q, best_d;
  logic [IDX_WIDTH-1:0] best_idx_q, best_idx_d;
  res_t                 res_q, res_d;
  logic                 valid_q, valid_d;

  logic                 accept, first, new_max, frame_end;
  logic [INWIDTH-1:0]   best_n;
  logic [IDX_WIDTH-1:0] idx_n;

  // Ready only in ACC, while enabled and out of reset.
  assign din_ready = reset_n & en & (state_q == ACC);
  assign accept    = din_valid & din_ready;
  assign first     = (count_q == '0);
  assign new_max   = first | ($signed(din_data) > $signed(best_q));
  assign frame_end = din_last | (count_q == LAST_IDX);
  // Running best including the current beat; ties keep the earlier index.
  assign best_n    = new_max ? din_data : best_q;
  assign idx_n     = new_max ? count_q  : best_idx_q;

`ifdef NN_ARGMAX_MARGIN_EN
  logic [INWIDTH-1:0]      second_q, second_d, second_n;
  logic [INWIDTH-1:0]      margin_q, margin_d, margin_n;
  logic signed [INWIDTH:0] diff;

  // Second-best tracking: a new maximum demotes the old best; otherwise the
  // beat competes with the current second. Frame start forgets the old frame.
  always_comb begin
    second_n = second_q;
    if (first)                                           second_n = MOST_NEG;
    else if (new_max)                                    second_n = best_q;
    else if ($signed(din_data) > $signed(second_q))      second_n = din_data;
    diff = $signed({best_n[INWIDTH-1], best_n}) - $signed({second_n[INWIDTH-1], second_n});
    // A single-beat frame has no real second best: report the widest margin.
    if (first || diff > $signed({1'b0, {INWIDTH{1'b1}}}))
      margin_n = {INWIDTH{1'b1}};
    else
      margin_n = diff[INWIDTH-1:0];
  end
`endif

  // Next-state: accumulate beats in ACC, park the result in HOLD until taken.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    res_d      = res_q;
    valid_d    = valid_q;
`ifdef NN_ARGMAX_MARGIN_EN
    second_d   = second_q;
    margin_d   = margin_q;
`endif
    case (state_q)
      ACC: begin
        if (accept) begin
          best_d     = best_n;
          best_idx_d = idx_n;
`ifdef NN_ARGMAX_MARGIN_EN
          second_d   = second_n;
`endif
          if (frame_end) begin
            res_d.cls   = idx_n;
            res_d.score = best_n;
            // Error unless the declared last beat lands exactly on the last slot.
            res_d.err   = ~(din_last & (count_q == LAST_IDX));
            valid_d     = 1'b1;
            count_d     = '0;
            state_d     = HOLD;
`ifdef NN_ARGMAX_MARGIN_EN
            margin_d    = margin_n;
`endif
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (en & dout_ready) begin
          valid_d = 1'b0;
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  // State registers; en=0 freezes everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ACC;
      count_q    <= '0;
      best_q     <= MOST_NEG;
      best_idx_q <= '0;
      res_q      <= '0;
      valid_q    <= 1'b0;
    end else if (en) begin
      state_q    <= state_d;
      count_q    <= count_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      res_q      <= res_d;
      valid_q    <= valid_d;
    end
  end

`ifdef NN_ARGMAX_MARGIN_EN
  // Second-best and margin registers, frozen with the rest.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      second_q <= MOST_NEG;
      margin_q <= '0;
    end else if (en) begin
      second_q <= second_d;
      margin_q <= margin_d;
    end
  end

  assign dout_margin = margin_q;
`endif

  assign dout_valid = valid_q;
  assign dout_class = res_q.cls;
  assign dout_score = res_q.score;
  assign dout_err   = res_q.err;

endmodule

// File: tb/tb_nn_argmax_head.sv
// Bench for nn_argmax_head: frame-level reference model (queue of accepted
// scores, argmax/sort on frame end), per-cycle compare on the falling edge,
// directed frames with literal expectations, then randomized traffic.
module tb_nn_argmax_head;
  localparam int W = 16;
  localparam int N = 10;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          reset_n, en, din_valid, din_last, dout_ready;
  logic [W-1:0]  din_data;
  logic          din_ready, dout_valid, dout_err;
  logic [IW-1:0] dout_class;
  logic [W-1:0]  dout_score;
`ifdef NN_ARGMAX_MARGIN_EN
  logic [W-1:0]  dout_margin;
`endif

  nn_argmax_head #(.INWIDTH(W), .NUM_CLASSES(N), .IDX_WIDTH(IW)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .din_valid(din_valid),
    .din_data(din_data), .din_ready(din_ready), .din_last(din_last),
    .dout_valid(dout_valid), .dout_class(dout_class), .dout_score(dout_score),
    .dout_err(dout_err), .dout_ready(dout_ready)
`ifdef NN_ARGMAX_MARGIN_EN
    , .dout_margin(dout_margin)
`endif
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model state
  int          vals[$];
  bit          hold = 0;
  bit          acc = 0;
  logic        exp_valid = 0, exp_err = 0;
  logic [IW-1:0] exp_class = '0;
  logic [W-1:0]  exp_score = '0, exp_margin = '0;

  task automatic model_clear();
    vals.delete();
    hold = 0; exp_valid = 0; exp_err = 0;
    exp_class = '0; exp_score = '0; exp_margin = '0;
  endtask

  // One clock edge worth of specification behaviour.
  task automatic model_step();
    int s[$];
    int bi;
    acc = 0;
    if (!en) return;
    if (!hold) begin
      if (din_valid) begin
        acc = 1;
        vals.push_back(int'($signed(din_data)));
        if (din_last || vals.size() == N) begin
          bi = 0;
          foreach (vals[i]) if (vals[i] > vals[bi]) bi = i;
          exp_class = IW'(bi);
          exp_score = W'(vals[bi]);
          exp_err   = !(din_last && vals.size() == N);
          if (vals.size() == 1) exp_margin = '1;
          else begin
            s = vals; s.rsort();
            exp_margin = W'(s[0] - s[1]);
          end
          exp_valid = 1;
          hold = 1;
          vals.delete();
        end
      end
    end else if (dout_ready) begin
      exp_valid = 0;
      hold = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step(); else acc = 0;
    #1;
  endtask

  task automatic send(input logic [W-1:0] v, input bit l);
    int n = 0;
    din_valid = 1; din_data = v; din_last = l;
    do begin tick(); n++; end while (!acc && n < 50);
    if (!acc) chk("accept_timeout", 0, 1);
    din_valid = 0; din_last = 0;
  endtask

  task automatic consume();
    dout_ready = 1; tick(); dout_ready = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    model_clear();
    #2;
    chk("rst_valid", dout_valid, 0);
    chk("rst_class", dout_class, 0);
    chk("rst_score", dout_score, 0);
    chk("rst_ready", din_ready, 0);
    tick();
    reset_n = 1;
  endtask

  // Cycle compare against the model while outputs are settled.
  always @(negedge clk) begin
    chk("din_ready", din_ready, reset_n & en & !hold);
    chk("dout_valid", dout_valid, exp_valid);
    chk("dout_class", dout_class, exp_class);
    chk("dout_score", dout_score, exp_score);
    chk("dout_err", dout_err, exp_err);
`ifdef NN_ARGMAX_MARGIN_EN
    chk("dout_margin", dout_margin, exp_margin);
`endif
  end

  logic [W-1:0] t1 [10];

  initial begin
    reset_n = 0; en = 1; din_valid = 0; din_last = 0; din_data = '0; dout_ready = 0;
    #2;
    chk("init_valid", dout_valid, 0);
    chk("init_ready", din_ready, 0);
    chk("init_err", dout_err, 0);
    #10;
    tick();
    reset_n = 1;

    // 1: mixed frame, max at beat 3
    t1 = '{16'h0010, 16'h0100, 16'hFFFF, 16'h0200, 16'h0000, 16'h0000,
           16'h0000, 16'h0000, 16'h0000, 16'h0050};
    dout_ready = 1;
    for (int i = 0; i < 10; i++) send(t1[i], i == 9);
    chk("t1_valid", dout_valid, 1);
    chk("t1_class", dout_class, 3);
    chk("t1_score", dout_score, 16'h0200);
    chk("t1_err", dout_err, 0);
    tick();
    dout_ready = 0;

    // 2: all ties at max positive
    for (int i = 0; i < 10; i++) send(16'h7FFF, i == 9);
    chk("t2_class", dout_class, 0);
    chk("t2_score", dout_score, 16'h7FFF);
`ifdef NN_ARGMAX_MARGIN_EN
    chk("t2_margin", dout_margin, 0);
`endif
    consume();

    // 3: ascending negatives
    for (int i = 0; i < 10; i++) send(W'(16'h8000 + i), i == 9);
    chk("t3_class", dout_class, 9);
    chk("t3_score", dout_score, 16'h8009);
    chk("t3_err", dout_err, 0);
`ifdef NN_ARGMAX_MARGIN_EN
    chk("t3_margin", dout_margin, 1);
`endif
    consume();

    // 4a: short frame, last on beat 3
    send(16'd5, 0); send(16'd9, 0); send(16'd9, 0); send(16'd2, 1);
    chk("t4a_err", dout_err, 1);
    chk("t4a_class", dout_class, 1);
    chk("t4a_score", dout_score, 16'd9);
    consume();
    // 4b: ten beats, no last
    for (int i = 0; i < 10; i++) send(W'(i + 1), 0);
    chk("t4b_err", dout_err, 1);
    chk("t4b_class", dout_class, 9);
    // 5: backpressure with din_valid asserted
    din_valid = 1; din_data = 16'h1234;
    repeat (5) tick();
    chk("t5_ready", din_ready, 0);
    chk("t5_hold_class", dout_class, 9);
    din_valid = 0;
    consume();
    // en=0 mid-frame
    for (int i = 0; i < 4; i++) send(W'(i * 3), 0);
    en = 0; din_valid = 1; din_data = 16'h7000;
    repeat (3) tick();
    en = 1; din_valid = 0;
    for (int i = 4; i < 10; i++) send(W'(20 - i), i == 9);
    chk("t5_class", dout_class, 4);
    chk("t5_score", dout_score, 16'd16);
    consume();

    // 6: reset mid-frame then fresh frame
    for (int i = 0; i < 6; i++) send(16'h7000, 0);
    do_reset();
    for (int i = 0; i < 10; i++) send(W'(i == 7 ? 100 : 1), i == 9);
    chk("t6_class", dout_class, 7);
    chk("t6_score", dout_score, 16'd100);
    chk("t6_err", dout_err, 0);
    consume();

    // single-beat frame
    send(16'hFFF0, 1);
    chk("sb_class", dout_class, 0);
    chk("sb_err", dout_err, 1);
`ifdef NN_ARGMAX_MARGIN_EN
    chk("sb_margin", dout_margin, 16'hFFFF);
`endif
    consume();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      en         = ($urandom_range(0, 9) != 0);
      din_valid  = ($urandom_range(0, 9) < 7);
      din_last   = ($urandom_range(0, 11) == 0);
      dout_ready = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 5))
        0: din_data = 16'h7FFF;
        1: din_data = 16'h8000;
        2: din_data = W'($urandom_range(0, 3));
        default: din_data = W'($urandom);
      endcase
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
